// File: rtl/sig_dump_uart_tx_if.sv
// Synchronous RAM read port used by sig_dump_uart_tx.
// The RAM returns mem_rdata exactly one cycle after mem_rd_en.
interface sig_dump_uart_tx_if;
   logic        mem_rd_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;

   modport master (output mem_rd_en, output mem_addr, input mem_rdata);
   modport slave  (input mem_rd_en, input mem_addr, output mem_rdata);
endinterface

// File: rtl/sig_dump_uart_tx.sv
// Walks RAM [begin_addr, end_addr) and streams each word as 8 lowercase hex digits plus a
// line terminator over 8N1 UART. Define SIG_DUMP_CRLF_EN to end each line with 0x0D 0x0A instead of 0x0A.
module sig_dump_uart_tx #(
   parameter int unsigned CLK_FREQ = 50000000,
   parameter int unsigned BAUD     = 115200
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [31:0]        begin_addr,
   input  logic [31:0]        end_addr,
   sig_dump_uart_tx_if.master mem,
   output logic               uart_tx,
   output logic               busy,
   output logic               done
);

   localparam int unsigned BIT_DIV = CLK_FREQ / BAUD;
   localparam int unsigned DIV_W   = $clog2(BIT_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
`ifdef SIG_DUMP_CRLF_EN
   localparam logic [3:0] LAST_BYTE = 4'd9;
`else
   localparam logic [3:0] LAST_BYTE = 4'd8;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_SEND,
      S_FIN
   } state_t;

   state_t          state, state_n;
   logic [31:0]     cur, cur_n;
   logic [31:0]     end_q, end_n;
   logic [31:0]     word, word_n;
   logic [3:0]      byte_idx, byte_idx_n;
   logic [8:0]      frame, frame_n;
   logic [3:0]      bit_idx, bit_idx_n;
   logic [DIV_W-1:0] div_cnt, div_n;
   logic            tx_q, tx_n;
   logic            busy_q, busy_n;
   logic            done_q, done_n;
   logic            rd_en_q, rd_en_n;
   logic [31:0]     addr_q, addr_n;

   logic            load_go;
   logic [31:0]     load_src;
   logic [3:0]      load_idx;
   logic [31:0]     begin_al, end_al;
   logic [32:0]     cur_inc;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
   endfunction

   function automatic logic [7:0] line_byte(input logic [3:0] idx, input logic [3:0] nib);
      if (idx < 4'd8) return hex_ascii(nib);
`ifdef SIG_DUMP_CRLF_EN
      if (idx == 4'd8) return 8'h0D;
`endif
      return 8'h0A;
   endfunction

   assign begin_al = begin_addr & ~32'h3;
   assign end_al   = end_addr & ~32'h3;
   assign cur_inc  = {1'b0, cur} + 33'd4;

   always_comb begin
      state_n    = state;
      cur_n      = cur;
      end_n      = end_q;
      word_n     = word;
      byte_idx_n = byte_idx;
      frame_n    = frame;
      bit_idx_n  = bit_idx;
      div_n      = div_cnt;
      tx_n       = tx_q;
      busy_n     = busy_q;
      done_n     = 1'b0;
      rd_en_n    = 1'b0;
      addr_n     = addr_q;
      load_go    = 1'b0;
      load_src   = word;
      load_idx   = byte_idx;

      case (state)
         S_IDLE: begin
            // done_q high means this is the completion cycle; a start there is dropped
            if (start && !done_q) begin
               cur_n  = begin_al;
               end_n  = end_al;
               busy_n = 1'b1;
               if (begin_al >= end_al) begin
                  state_n = S_FIN;
               end else begin
                  state_n = S_FETCH;
                  rd_en_n = 1'b1;
                  addr_n  = begin_al;
               end
            end
         end
         S_FETCH: state_n = S_WAIT;
         S_WAIT: begin
            load_go  = 1'b1;
            load_src = mem.mem_rdata;
            load_idx = 4'd0;
         end
         S_SEND: begin
            if (div_cnt == DIV_LAST) begin
               div_n = '0;
               if (bit_idx != 4'd9) begin
                  bit_idx_n = bit_idx + 4'd1;
                  tx_n      = frame[0];
                  frame_n   = {1'b1, frame[8:1]};
               end else if (byte_idx != LAST_BYTE) begin
                  load_go  = 1'b1;
                  load_idx = byte_idx + 4'd1;
               end else if (cur_inc[32] || (cur_inc[31:0] >= end_q)) begin
                  state_n = S_FIN;
               end else begin
                  cur_n   = cur_inc[31:0];
                  state_n = S_FETCH;
                  rd_en_n = 1'b1;
                  addr_n  = cur_inc[31:0];
               end
            end else begin
               div_n = div_cnt + DIV_W'(1);
            end
         end
         S_FIN: begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase

      // LOAD is folded into the cycle that ends WAIT or the previous stop bit,
      // so the next start bit follows with no idle gap.
      if (load_go) begin
         state_n    = S_SEND;
         byte_idx_n = load_idx;
         frame_n    = {1'b1, line_byte(load_idx, load_src[31:28])};
         word_n     = {load_src[27:0], 4'h0};
         bit_idx_n  = 4'd0;
         div_n      = '0;
         tx_n       = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cur      <= '0;
         end_q    <= '0;
         word     <= '0;
         byte_idx <= '0;
         frame    <= '1;
         bit_idx  <= '0;
         div_cnt  <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         rd_en_q  <= 1'b0;
         addr_q   <= '0;
      end else begin
         state    <= state_n;
         cur      <= cur_n;
         end_q    <= end_n;
         word     <= word_n;
         byte_idx <= byte_idx_n;
         frame    <= frame_n;
         bit_idx  <= bit_idx_n;
         div_cnt  <= div_n;
         tx_q     <= tx_n;
         busy_q   <= busy_n;
         done_q   <= done_n;
         rd_en_q  <= rd_en_n;
         addr_q   <= addr_n;
      end
   end

   assign uart_tx       = tx_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign mem.mem_rd_en = rd_en_q;
   assign mem.mem_addr  = addr_q;

endmodule

// File: tb/tb_sig_dump_uart_tx.sv
// Bench for sig_dump_uart_tx: a cycle-level timeline model of the dump plus a UART byte decoder.
// Build with SIG_DUMP_CRLF_EN defined to exercise CR LF line endings.
module tb_sig_dump_uart_tx;
   localparam int BD = 16;
   localparam int FR = 10 * BD;
`ifdef SIG_DUMP_CRLF_EN
   localparam int NB = 10;
`else
   localparam int NB = 9;
`endif
   localparam int P = NB * FR + 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] begin_addr;
   logic [31:0] end_addr;
   logic        uart_tx;
   logic        busy;
   logic        done;

   sig_dump_uart_tx_if mif ();

   sig_dump_uart_tx #(.CLK_FREQ(16), .BAUD(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .begin_addr (begin_addr),
      .end_addr   (end_addr),
      .mem        (mif),
      .uart_tx    (uart_tx),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   logic [31:0] ram [logic [31:0]];

   function automatic logic [31:0] ram_rd(input logic [31:0] a);
      return ram.exists(a) ? ram[a] : 32'h0;
   endfunction

   always @(posedge clk) if (mif.mem_rd_en === 1'b1) mif.mem_rdata <= ram_rd(mif.mem_addr);

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Byte k of the text line for word w
   function automatic logic [7:0] exp_byte(input logic [31:0] w, input int k);
      logic [3:0] nib;
      if (k < 8) begin
         nib = 4'((w >> (28 - 4 * k)) & 32'hf);
         return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h61 + {4'h0, nib} - 8'd10);
      end
      if (NB == 10 && k == 8) return 8'h0D;
      return 8'h0A;
   endfunction

   // Timeline model: dump accepted in cycle m_c, word w's frames start at m_c+3+w*P
   int          cyc = 0;
   bit          m_active = 1'b0;
   int          m_c, m_nw;
   logic [31:0] m_b;
   logic [31:0] m_words[$];
   logic [31:0] m_last_addr = 32'h0;
   int          acc_cyc = 0, done_cyc = 0, n_reads = 0;
   logic [31:0] rd_q[$];

   always @(negedge clk) begin : model
      int d, rel, w, r, kb, bt;
      logic e_busy, e_done, e_rd, e_tx;
      logic [31:0] e_addr, eb, ee;
      logic [7:0] by;
      cyc++;
      e_busy = 1'b0; e_done = 1'b0; e_rd = 1'b0; e_tx = 1'b1; e_addr = m_last_addr;
      if (m_active) begin
         d = cyc - m_c;
         e_busy = d < 2 + m_nw * P;
         e_done = d == 2 + m_nw * P;
         if ((d - 1) % P == 0 && (d - 1) / P < m_nw) begin
            e_rd   = 1'b1;
            e_addr = m_b + 32'(4 * ((d - 1) / P));
         end
         if (d >= 3) begin
            rel = d - 3; w = rel / P; r = rel % P;
            if (w < m_nw && r < NB * FR) begin
               kb = r / FR; bt = (r % FR) / BD;
               by = exp_byte(m_words[w], kb);
               e_tx = (bt == 0) ? 1'b0 : (bt == 9) ? 1'b1 : by[bt - 1];
            end
         end
      end
      chk("uart_tx", uart_tx, e_tx);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("mem_rd_en", mif.mem_rd_en, e_rd);
      chk("mem_addr", mif.mem_addr, e_addr);
      if (mif.mem_rd_en === 1'b1) begin
         n_reads++;
         rd_q.push_back(mif.mem_addr);
      end
      if (done === 1'b1) done_cyc = cyc;
      m_last_addr = e_addr;
      if (e_done) m_active = 1'b0;
      if (rst) begin
         m_active    = 1'b0;
         m_last_addr = 32'h0;
      end else if (start && !e_busy && !e_done) begin
         eb = begin_addr & ~32'h3;
         ee = end_addr & ~32'h3;
         m_active = 1'b1;
         m_c      = cyc;
         acc_cyc  = cyc;
         m_b      = eb;
         m_nw     = (eb >= ee) ? 0 : int'((ee - eb) >> 2);
         m_words.delete();
         for (int i = 0; i < m_nw; i++) m_words.push_back(ram_rd(eb + 32'(4 * i)));
      end
   end

   // UART receiver sampling mid-bit
   logic [7:0] rx_q[$];
   bit         rx_on = 1'b0;
   int         rx_off = 0;
   logic [7:0] rx_byte;

   always @(negedge clk) begin
      if (rst) begin
         rx_on = 1'b0;
      end else if (!rx_on) begin
         if (uart_tx === 1'b0) begin
            rx_on  = 1'b1;
            rx_off = 0;
         end
      end else begin
         rx_off++;
         if (rx_off >= 24 && rx_off <= 136 && rx_off % 16 == 8) rx_byte[(rx_off - 24) / 16] = uart_tx;
         if (rx_off == 152) begin
            rx_q.push_back(rx_byte);
            rx_on = 1'b0;
         end
      end
   end

   logic [7:0] xq[$];

   function automatic void xq_line(input string s);
      for (int i = 0; i < s.len(); i++) xq.push_back(s[i]);
      if (NB == 10) xq.push_back(8'h0D);
      xq.push_back(8'h0A);
   endfunction

   task automatic chk_rx(input string name);
      chk({name, "_count"}, rx_q.size(), xq.size());
      for (int i = 0; i < xq.size(); i++)
         chk(name, (i < rx_q.size()) ? rx_q[i] : 8'hxx, xq[i]);
   endtask

   task automatic pulse(input logic [31:0] b, input logic [31:0] e);
      @(posedge clk); #1;
      start = 1'b1; begin_addr = b; end_addr = e;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic dump(input logic [31:0] b, input logic [31:0] e, input int nw);
      bit ok;
      rx_q.delete(); rd_q.delete(); n_reads = 0;
      pulse(b, e);
      ok = 1'b0;
      for (int i = 0; i < 2 + nw * P + 20 && !ok; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) ok = 1'b1;
      end
      chk("done_seen", 32'(ok), 32'd1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, expected finish within 100000 cycles");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] lit1 [9];
      logic [31:0] b, e;
      int nw;
      rst = 1'b1; start = 1'b0; begin_addr = '0; end_addr = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // idle after reset
      repeat (50) @(posedge clk);
      #1;
      chk("idle_uart_tx", uart_tx, 1'b1);
      chk("idle_busy", busy, 1'b0);
      chk("idle_done", done, 1'b0);
      chk("idle_reads", n_reads, 0);

      // model pinned against hand-decoded text of 0x1234abcd
      lit1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h61, 8'h62, 8'h63, 8'h64, 8'h0A};
      for (int k = 0; k < 8; k++) chk("model_hex", exp_byte(32'h1234abcd, k), lit1[k]);
      chk("model_term", exp_byte(32'h1234abcd, NB - 1), 8'h0A);

      // one word
      ram[32'h100] = 32'h1234abcd;
      dump(32'h100, 32'h104, 1);
      chk("one_reads", n_reads, 1);
      chk("one_addr", (rd_q.size() > 0) ? rd_q[0] : 32'hx, 32'h100);
      xq.delete();
      for (int k = 0; k < 8; k++) xq.push_back(lit1[k]);
      if (NB == 10) xq.push_back(8'h0D);
      xq.push_back(8'h0A);
      chk_rx("one_bytes");
      chk("one_latency", done_cyc - acc_cyc, (NB == 9) ? 1444 : 1604);

      // three words
      ram[32'h200] = 32'h00000000;
      ram[32'h204] = 32'hffffffff;
      ram[32'h208] = 32'h80000001;
      dump(32'h200, 32'h20C, 3);
      chk("three_reads", n_reads, 3);
      for (int i = 0; i < 3; i++)
         chk("three_addr", (i < rd_q.size()) ? rd_q[i] : 32'hx, 32'h200 + 32'(4 * i));
      xq.delete();
      xq_line("00000000"); xq_line("ffffffff"); xq_line("80000001");
      chk_rx("three_bytes");
      chk("three_frames", rx_q.size(), 3 * NB);

      // empty ranges
      dump(32'h10, 32'h10, 0);
      chk("empty_eq_reads", n_reads, 0);
      chk("empty_eq_frames", rx_q.size(), 0);
      chk("empty_eq_latency", done_cyc - acc_cyc, 2);
      dump(32'h20, 32'h10, 0);
      chk("empty_gt_reads", n_reads, 0);
      chk("empty_gt_frames", rx_q.size(), 0);
      chk("empty_gt_latency", done_cyc - acc_cyc, 2);

      // start while busy, then reset inside data bit d3 of the third character 'a'
      ram[32'h300] = 32'hdeadbeef;
      rx_q.delete(); n_reads = 0;
      pulse(32'h300, 32'h304);
      repeat (100) @(posedge clk);
      #1;
      pulse(32'h10, 32'h20);
      repeat (292) @(posedge clk);
      #1;
      chk("pre_rst_tx", uart_tx, 1'b0);
      chk("pre_rst_busy", busy, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("post_rst_tx", uart_tx, 1'b1);
      chk("post_rst_busy", busy, 1'b0);
      chk("post_rst_addr", mif.mem_addr, 32'h0);
      chk("abort_reads", n_reads, 1);
      repeat (5) @(posedge clk);
      #1;
      dump(32'h300, 32'h304, 1);
      xq.delete();
      xq_line("deadbeef");
      chk_rx("restart_bytes");

      // randomized ranges and contents
      for (int t = 0; t < 6; t++) begin
         nw = $urandom_range(0, 2);
         b  = 32'h400 + 32'(t * 32'h40) + 32'($urandom_range(0, 3));
         for (int i = 0; i < nw; i++) ram[(b & ~32'h3) + 32'(4 * i)] = $urandom;
         e  = (b & ~32'h3) + 32'(4 * nw) + 32'($urandom_range(0, 3));
         dump(b, e, nw);
         chk("rand_reads", n_reads, nw);
         xq.delete();
         for (int i = 0; i < nw; i++)
            for (int k = 0; k < NB; k++) xq.push_back(exp_byte(ram_rd((b & ~32'h3) + 32'(4 * i)), k));
         chk_rx("rand_bytes");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
